// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts one request, shifts STEP bits per cycle,
// and holds the full-width result until the consumer takes it.
module shift_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 6,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_op1,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [1:0]         req_operation,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_res,
    output logic               resp_err,
    output logic               busy
);

    localparam int REM_W = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [REM_W-1:0] REM_MAX = REM_W'(DATA_W);
    localparam logic [REM_W-1:0] STEP_N  = REM_W'(STEP);

    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [1:0]          op_q, op_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                err_q, err_d;

    logic [REM_W-1:0]    shamt_sat_s;
    logic [REM_W-1:0]    step_n_s;
    logic [2*DATA_W-1:0] sra_wide_s;
    logic [DATA_W-1:0]   shifted_s;

    // Saturate the requested amount at DATA_W and pick this cycle's step size.
    always_comb begin
        if (32'(req_shamt) >= 32'(DATA_W)) begin
            shamt_sat_s = REM_MAX;
        end else begin
            shamt_sat_s = REM_W'(req_shamt);
        end
        if (rem_q < STEP_N) begin
            step_n_s = rem_q;
        end else begin
            step_n_s = STEP_N;
        end
    end

    // One partial shift of the accumulator; the sign word above acc supplies the fill.
    always_comb begin
        sra_wide_s = {{DATA_W{sign_q}}, acc_q} >> step_n_s;
        case (op_q)
            OP_SRA:  shifted_s = sra_wide_s[DATA_W-1:0];
            OP_SLL:  shifted_s = acc_q << step_n_s;
            OP_SRL:  shifted_s = acc_q >> step_n_s;
            default: shifted_s = acc_q >> step_n_s;
        endcase
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    acc_d  = req_op1;
                    op_d   = req_operation;
                    sign_d = req_op1[DATA_W-1];
                    rem_d  = shamt_sat_s;
                    if (req_operation == OP_ILL) begin
                        res_d   = {DATA_W{1'b0}};
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (shamt_sat_s == {REM_W{1'b0}}) begin
                        res_d   = req_op1;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = shifted_s;
                rem_d = rem_q - step_n_s;
                if (rem_q == step_n_s) begin
                    res_d   = shifted_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= {DATA_W{1'b0}};
            rem_q   <= {REM_W{1'b0}};
            op_q    <= 2'b00;
            sign_q  <= 1'b0;
            res_q   <= {DATA_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req_ready  = rst_n & (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_res   = res_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_op1 = 32'h0;
    logic [5:0]  req_shamt = 6'h0;
    logic [1:0]  req_operation = 2'b00;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_res;
    logic        resp_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model state: whether a request is in flight, cycles left, visible result.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_res = 32'h0;
    logic        m_err = 1'b0;
    logic [31:0] p_res = 32'h0;

    shift_seq_ctrl #(.DATA_W(32), .SHAMT_W(6), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_shamt(req_shamt), .req_operation(req_operation),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_res(resp_res), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result, error flag and latency from the arithmetic meaning of the request.
    task automatic exp_calc(input logic [31:0] op1, input logic [5:0] sh, input logic [1:0] op,
                            output logic [31:0] res, output logic err, output int lat);
        int s;
        s = (int'(sh) > 32) ? 32 : int'(sh);
        err = (op == 2'b11);
        case (op)
            2'b00:   res = (s == 32) ? 32'h0 : (op1 >> s);
            2'b01:   res = (s == 32) ? {32{op1[31]}} : 32'($signed(op1) >>> s);
            2'b10:   res = (s == 32) ? 32'h0 : (op1 << s);
            default: res = 32'h0;
        endcase
        if (err || s == 0) lat = 1;
        else lat = 1 + (s + 3) / 4;
    endtask

    // Reference model advances on each rising edge from the inputs the bench drives.
    always @(posedge clk) begin
        logic [31:0] r;
        logic        e;
        int          l;
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_wait = 0; m_res = 32'h0; m_err = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                exp_calc(req_op1, req_shamt, req_operation, r, e, l);
                m_busy = 1'b1;
                m_err  = e;
                p_res  = r;
                if (l == 1) begin
                    m_valid = 1'b1;
                    m_res   = r;
                end else begin
                    m_wait = l - 1;
                end
            end
        end else if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_res   = p_res;
            end
        end else if (resp_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(rst_n && !m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("resp_valid", 32'(resp_valid), 32'(m_valid));
            chk("resp_res", resp_res, m_res);
            chk("resp_err", 32'(resp_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] op1, input logic [5:0] sh, input logic [1:0] op,
                          input bit lit, input logic [31:0] lres, input logic lerr,
                          input int llat, input int hold);
        logic [31:0] mres;
        logic        merr;
        int          mlat;
        int          k;
        if (lit) begin
            exp_calc(op1, sh, op, mres, merr, mlat);
            chk("model_res", mres, lres);
            chk("model_err", 32'(merr), 32'(lerr));
            chk("model_lat", 32'(mlat), 32'(llat));
        end
        req_valid = 1'b1; req_op1 = op1; req_shamt = sh; req_operation = op;
        tick();
        req_valid = 1'b0;
        req_op1 = $urandom; req_shamt = 6'($urandom); req_operation = 2'($urandom);
        k = 1;
        while (!resp_valid && k < 200) begin
            tick();
            k++;
        end
        if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'h1);
        if (lit) begin
            chk("latency", 32'(k), 32'(llat));
            chk("lit_res", resp_res, lres);
            chk("lit_err", 32'(resp_err), 32'(lerr));
        end
        repeat (hold) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_res", resp_res, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();

        do_req(32'hF000_0000, 6'd4,  2'b00, 1'b1, 32'h0F00_0000, 1'b0, 2, 0);
        do_req(32'h8000_0000, 6'd31, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, 9, 1);
        do_req(32'h8000_0000, 6'd63, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, 9, 0);
        do_req(32'h0000_0001, 6'd40, 2'b10, 1'b1, 32'h0000_0000, 1'b0, 9, 2);
        do_req(32'h1234_5678, 6'd0,  2'b00, 1'b1, 32'h1234_5678, 1'b0, 1, 0);
        do_req(32'hDEAD_BEEF, 6'd5,  2'b11, 1'b1, 32'h0000_0000, 1'b1, 1, 0);
        do_req(32'h8000_0000, 6'd4,  2'b01, 1'b1, 32'hF800_0000, 1'b0, 2, 0);
        do_req(32'h0000_0001, 6'd31, 2'b10, 1'b1, 32'h8000_0000, 1'b0, 9, 0);
        do_req(32'hFFFF_FFFF, 6'd6,  2'b00, 1'b1, 32'h03FF_FFFF, 1'b0, 3, 1);

        // Backpressure: a second request waits while the first result is held.
        req_valid = 1'b1; req_op1 = 32'h0000_00F0; req_shamt = 6'd4; req_operation = 2'b00;
        tick();
        req_op1 = 32'hA5A5_A5A5; req_shamt = 6'd8; req_operation = 2'b10;
        k = 0;
        while (!resp_valid && k < 50) begin
            tick();
            k++;
        end
        chk("bp_first_valid", 32'(resp_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_res", resp_res, 32'h0000_000F);
            chk("bp_err", 32'(resp_err), 32'h0);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_ready_after", 32'(req_ready), 32'h1);
        chk("bp_not_taken", 32'(busy), 32'h0);
        tick();
        req_valid = 1'b0;
        chk("bp_accepted", 32'(busy), 32'h1);
        k = 1;
        while (!resp_valid && k < 50) begin
            tick();
            k++;
        end
        chk("bp_second_lat", 32'(k), 32'd3);
        chk("bp_second_res", resp_res, 32'hA5A5_A500);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset in the middle of a long shift.
        req_valid = 1'b1; req_op1 = 32'hFFFF_FFFF; req_shamt = 6'd20; req_operation = 2'b00;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_valid", 32'(resp_valid), 32'h0);
        chk("mid_rst_res", resp_res, 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("no_stale_resp", 32'(resp_valid), 32'h0);
        end

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req($urandom, 6'($urandom_range(0, 63)), op, 1'b0, 32'h0, 1'b0, 0,
                   int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
